branch_fwd_unit: RTL and testbench
==================================

BRANCH_FWD_UNIT -- requirements
Module: branch_fwd_unit

Interface
REQ-001 Parameter XLEN, default 32, data width of all operand/result buses.
REQ-002 Parameter NPORT, default 2, number of decode operand ports forwarded independently.
REQ-003 Parameter LO_DEPTH, default 4 (power of two, >=2), in-flight long-latency (div/mul) operation tracking depth.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 id_rs_addr  in  NPORT x 5  decode source register addresses.
REQ-007 id_rs_val  in  NPORT x XLEN  register-file read values.
REQ-008 ex_regwrite, ex_memread  in  1 each  EX/MEM stage writes rd / is a load.
REQ-009 ex_rd  in  5, ex_res  in  XLEN  EX/MEM destination and ALU result.
REQ-010 wb_regwrite  in  1, wb_rd  in  5, wb_res  in  XLEN  MEM/WB write-back.
REQ-011 lo_issue  in  1, lo_rd  in  5  long op enters execution, destination rd.
REQ-012 lo_done  in  1, lo_res  in  XLEN  oldest long op completes (in order), result.
REQ-013 rs_mod  out  NPORT x XLEN  forwarded operand values.
REQ-014 stall  out  1  decode must hold; operands not yet available.
REQ-015 lo_full  out  1  tracking queue holds LO_DEPTH entries.
REQ-016 lo_err  out  1  sticky overflow/underflow flag.
REQ-017 stall_cnt  out  32  saturating count of stall cycles.

Function
REQ-018 Tracking queue: FIFO of LO_DEPTH rd entries, write pointer, read pointer, count (0..LO_DEPTH); lo_full = (count==LO_DEPTH).
REQ-019 lo_issue with count<LO_DEPTH pushes lo_rd; lo_done with count>0 pops head; pointers wrap modulo LO_DEPTH.
REQ-020 Simultaneous lo_issue and lo_done when full: both accepted, count unchanged; when empty: issue accepted, done treated as underflow.
REQ-021 lo_issue while full without lo_done: entry dropped, lo_err set; lo_done while count==0: no pop, lo_err set; lo_err clears only on reset.
REQ-022 Bypass register: on lo_done with count>0, capture (head rd, lo_res) with valid=1 for exactly the next cycle, then valid=0.
REQ-023 Per port, address 0 never forwards nor stalls; rs_mod = 0 regardless of id_rs_val.
REQ-024 Per port, forwarding priority (first match wins): EX (ex_regwrite, !ex_memread, ex_rd==addr) -> ex_res; completing long op (lo_done, count>0, head rd==addr) -> lo_res; bypass (valid, rd==addr) -> captured value; WB (wb_regwrite, wb_rd==addr) -> wb_res; else id_rs_val.
REQ-025 stall = OR over ports (addr!=0) of: load-use (ex_regwrite, ex_memread, ex_rd==addr); any queued entry ==addr excluding the head when it is completing this cycle; lo_issue with lo_rd==addr.
REQ-026 Forwarding and stall are combinational from current inputs and state; zero-cycle latency.
REQ-027 stall_cnt increments by 1 each cycle stall=1, saturates at 0xFFFFFFFF.
REQ-028 Long ops do not assert ex_regwrite; the unit does not check this.

Reset
REQ-029 rst_n low asynchronously clears pointers, count, bypass valid, lo_err, stall_cnt; lo_full=0.
REQ-030 During and after reset with no inputs active, rs_mod = id_rs_val (0 for addr 0), stall=0.
REQ-031 Reset mid-operation discards all queued entries; no completion issued before reset affects forwarding after release.

Verification
REQ-032 rs1=x5, ex_regwrite=1, ex_rd=5, ex_res=0x11, wb_rd=5, wb_res=0x22 -> rs_mod[0]=0x11, stall=0.
REQ-033 ex_memread=1, ex_rd=7, rs2=x7 -> stall=1, stall_cnt increments by 1 per cycle held.
REQ-034 Issue div rd=9, rs1=x9 for 3 cycles -> stall=1; lo_done, lo_res=0xABCD -> same cycle stall=0, rs_mod[0]=0xABCD; next cycle bypass gives 0xABCD; following cycle id_rs_val.
REQ-035 Issue 4 long ops (full), 5th issue -> lo_full=1, lo_err=1, count stays 4; issue+done same cycle while full -> count 4, no error change.
REQ-036 lo_done with empty queue -> lo_err=1, no bypass capture; assert rst_n low mid-queue -> count=0, lo_err=0, stall_cnt=0 immediately.
REQ-037 rs addr 0 with EX/WB/long-op writes to rd 0 -> rs_mod=0, stall=0.

Source files
------------

// File: rtl/branch_fwd_unit_if.sv
// Bundle of decode-stage operand, pipeline write-back and long-op signals
// seen by branch_fwd_unit.
//   master : pipeline side, drives operand addresses/values, EX/WB and
//            long-op events; observes forwarded operands and status.
//   slave  : forwarding unit side.
// Ports carried:
//   id_rs_addr/id_rs_val          decode source addresses and RF values
//   ex_regwrite/ex_memread/ex_rd/ex_res   EX/MEM stage
//   wb_regwrite/wb_rd/wb_res      MEM/WB write-back
//   lo_issue/lo_rd/lo_done/lo_res long-latency op issue/completion
//   rs_mod/stall/lo_full/lo_err/stall_cnt outputs of the unit
interface branch_fwd_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NPORT = 2
);
    logic [NPORT-1:0][4:0]      id_rs_addr;
    logic [NPORT-1:0][XLEN-1:0] id_rs_val;
    logic                       ex_regwrite;
    logic                       ex_memread;
    logic [4:0]                 ex_rd;
    logic [XLEN-1:0]            ex_res;
    logic                       wb_regwrite;
    logic [4:0]                 wb_rd;
    logic [XLEN-1:0]            wb_res;
    logic                       lo_issue;
    logic [4:0]                 lo_rd;
    logic                       lo_done;
    logic [XLEN-1:0]            lo_res;
    logic [NPORT-1:0][XLEN-1:0] rs_mod;
    logic                       stall;
    logic                       lo_full;
    logic                       lo_err;
    logic [31:0]                stall_cnt;

    modport master (
        output id_rs_addr, id_rs_val,
        output ex_regwrite, ex_memread, ex_rd, ex_res,
        output wb_regwrite, wb_rd, wb_res,
        output lo_issue, lo_rd, lo_done, lo_res,
        input  rs_mod, stall, lo_full, lo_err, stall_cnt
    );

    modport slave (
        input  id_rs_addr, id_rs_val,
        input  ex_regwrite, ex_memread, ex_rd, ex_res,
        input  wb_regwrite, wb_rd, wb_res,
        input  lo_issue, lo_rd, lo_done, lo_res,
        output rs_mod, stall, lo_full, lo_err, stall_cnt
    );
endinterface

// File: rtl/branch_fwd_unit.sv
// Operand forwarding and hazard detection for the decode stage.
// Tracks in-flight long-latency (div/mul) destinations in an in-order FIFO,
// forwards EX, completing long-op, one-cycle long-op bypass and WB results,
// and raises stall on load-use or pending long-op destinations.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    branch_fwd_unit_if slave modport (all pipeline signals/outputs)
module branch_fwd_unit #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NPORT    = 2,
    parameter int unsigned LO_DEPTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    branch_fwd_unit_if.slave bus
);
    localparam int unsigned PW      = $clog2(LO_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(LO_DEPTH);

    logic [4:0]                 q_rd [LO_DEPTH];
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [PW:0]                count;
    logic                       byp_valid;
    logic [4:0]                 byp_rd;
    logic [XLEN-1:0]            byp_val;
    logic                       err_q;
    logic [31:0]                stall_cnt_q;

    logic                       full;
    logic                       empty;
    logic                       push;
    logic                       pop;
    logic [4:0]                 head_rd;
    logic [NPORT-1:0][XLEN-1:0] rs_mod_c;
    logic [NPORT-1:0]           q_hit;
    logic [PW-1:0]              slot;
    logic                       stall_c;

    assign full    = (count == DEPTH_C);
    assign empty   = (count == '0);
    assign pop     = bus.lo_done && !empty;
    // A full queue still accepts an issue when the head retires the same cycle.
    assign push    = bus.lo_issue && (!full || bus.lo_done);
    assign head_rd = q_rd[rd_ptr];

    always_comb begin
        rs_mod_c = '0;
        q_hit    = '0;
        slot     = '0;
        stall_c  = 1'b0;
        for (int unsigned p = 0; p < NPORT; p++) begin
            if (bus.id_rs_addr[p] != 5'd0) begin
                // Pending destinations; the head is excluded when it retires now,
                // since its result is forwarded instead.
                for (int unsigned i = 0; i < LO_DEPTH; i++) begin
                    slot = rd_ptr + PW'(i);
                    if (((PW+1)'(i) < count) && !((i == 0) && pop) &&
                        (q_rd[slot] == bus.id_rs_addr[p]))
                        q_hit[p] = 1'b1;
                end

                if (bus.ex_regwrite && !bus.ex_memread && (bus.ex_rd == bus.id_rs_addr[p]))
                    rs_mod_c[p] = bus.ex_res;
                else if (pop && (head_rd == bus.id_rs_addr[p]))
                    rs_mod_c[p] = bus.lo_res;
                else if (byp_valid && (byp_rd == bus.id_rs_addr[p]))
                    rs_mod_c[p] = byp_val;
                else if (bus.wb_regwrite && (bus.wb_rd == bus.id_rs_addr[p]))
                    rs_mod_c[p] = bus.wb_res;
                else
                    rs_mod_c[p] = bus.id_rs_val[p];

                if ((bus.ex_regwrite && bus.ex_memread && (bus.ex_rd == bus.id_rs_addr[p])) ||
                    q_hit[p] ||
                    (bus.lo_issue && (bus.lo_rd == bus.id_rs_addr[p])))
                    stall_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < LO_DEPTH; i++)
                q_rd[i] <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            byp_valid   <= 1'b0;
            byp_rd      <= '0;
            byp_val     <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            if (push) begin
                q_rd[wr_ptr] <= bus.lo_rd;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase

            byp_valid <= pop;
            if (pop) begin
                byp_rd  <= head_rd;
                byp_val <= bus.lo_res;
            end

            if ((bus.lo_issue && full && !bus.lo_done) || (bus.lo_done && empty))
                err_q <= 1'b1;

            if (stall_c && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign bus.rs_mod    = rs_mod_c;
    assign bus.stall     = stall_c;
    assign bus.lo_full   = full;
    assign bus.lo_err    = err_q;
    assign bus.stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_branch_fwd_unit.sv
// Self-checking bench for branch_fwd_unit: directed scenarios followed by
// randomized traffic, compared against a queue-based reference model.
module tb_branch_fwd_unit;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned NPORT = 2;
    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_fwd_unit_if #(.XLEN(XLEN), .NPORT(NPORT)) bus ();

    branch_fwd_unit #(.XLEN(XLEN), .NPORT(NPORT), .LO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    int unsigned m_q[$];
    bit          m_bv;
    logic [4:0]  m_brd;
    logic [31:0] m_bval;
    bit          m_err;
    logic [31:0] m_scnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic logic [31:0] exp_fwd(int unsigned p);
        int unsigned a = bus.id_rs_addr[p];
        if (a == 0) return 32'd0;
        if (bus.ex_regwrite && !bus.ex_memread && bus.ex_rd == a) return bus.ex_res;
        if (bus.lo_done && m_q.size() > 0 && m_q[0] == a) return bus.lo_res;
        if (m_bv && m_brd == a) return m_bval;
        if (bus.wb_regwrite && bus.wb_rd == a) return bus.wb_res;
        return bus.id_rs_val[p];
    endfunction

    function automatic bit exp_stall();
        for (int unsigned p = 0; p < NPORT; p++) begin
            int unsigned a = bus.id_rs_addr[p];
            int unsigned first = (bus.lo_done && m_q.size() > 0) ? 1 : 0;
            if (a == 0) continue;
            if (bus.ex_regwrite && bus.ex_memread && bus.ex_rd == a) return 1'b1;
            for (int unsigned k = first; k < m_q.size(); k++)
                if (m_q[k] == a) return 1'b1;
            if (bus.lo_issue && bus.lo_rd == a) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_all();
        for (int unsigned p = 0; p < NPORT; p++)
            check($sformatf("rs_mod[%0d]", p), bus.rs_mod[p], exp_fwd(p));
        check("stall", 32'(bus.stall), 32'(exp_stall()));
        check("lo_full", 32'(bus.lo_full), 32'(m_q.size() == DEPTH));
        check("lo_err", 32'(bus.lo_err), 32'(m_err));
        check("stall_cnt", bus.stall_cnt, m_scnt);
    endtask

    task automatic model_clock();
        bit          st     = exp_stall();
        int unsigned sz0    = m_q.size();
        bit          popped = bus.lo_done && sz0 > 0;
        int unsigned head   = popped ? m_q[0] : 0;
        if (bus.lo_done && !popped) m_err = 1'b1;
        if (popped) void'(m_q.pop_front());
        if (bus.lo_issue) begin
            if (sz0 < DEPTH || popped) m_q.push_back(bus.lo_rd);
            else m_err = 1'b1;
        end
        m_bv = popped;
        if (popped) begin
            m_brd  = 5'(head);
            m_bval = bus.lo_res;
        end
        if (st && m_scnt != 32'hFFFF_FFFF) m_scnt = m_scnt + 1;
    endtask

    // called at negedge with inputs driven; returns at the next negedge
    task automatic step();
        #1 check_all();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic idle();
        for (int unsigned p = 0; p < NPORT; p++) begin
            bus.id_rs_addr[p] = 5'd0;
            bus.id_rs_val[p]  = $urandom;
        end
        bus.ex_regwrite = 1'b0; bus.ex_memread = 1'b0; bus.ex_rd = 5'd0; bus.ex_res = $urandom;
        bus.wb_regwrite = 1'b0; bus.wb_rd = 5'd0; bus.wb_res = $urandom;
        bus.lo_issue = 1'b0; bus.lo_rd = 5'd0; bus.lo_done = 1'b0; bus.lo_res = $urandom;
    endtask

    // asynchronous reset asserted mid-cycle; keeps current operand addresses
    task automatic do_reset();
        bus.ex_regwrite = 1'b0; bus.ex_memread = 1'b0; bus.wb_regwrite = 1'b0;
        bus.lo_issue = 1'b0; bus.lo_done = 1'b0;
        #2 rst_n = 1'b0;
        m_q.delete(); m_bv = 1'b0; m_err = 1'b0; m_scnt = '0;
        #1;
        check("rst_lo_full", 32'(bus.lo_full), 32'd0);
        check("rst_lo_err", 32'(bus.lo_err), 32'd0);
        check("rst_stall_cnt", bus.stall_cnt, 32'd0);
        check_all();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        bus.id_rs_addr[0] = 5'd3;
        bus.id_rs_addr[1] = 5'd0;
        m_bv = 1'b0; m_err = 1'b0; m_scnt = '0; m_brd = '0; m_bval = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_rs0", bus.rs_mod[0], bus.id_rs_val[0]);
        check("reset_rs1_zero", bus.rs_mod[1], 32'd0);
        check("reset_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // EX has priority over WB
        idle();
        bus.id_rs_addr[0] = 5'd5;
        bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd5; bus.ex_res = 32'h11;
        bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd5; bus.wb_res = 32'h22;
        #1;
        check("ex_over_wb", bus.rs_mod[0], 32'h11);
        check("ex_no_stall", 32'(bus.stall), 32'd0);
        step();

        // load-use stall, counter steps each held cycle
        idle();
        do_reset();
        bus.id_rs_addr[1] = 5'd7;
        bus.ex_regwrite = 1'b1; bus.ex_memread = 1'b1; bus.ex_rd = 5'd7;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("load_use_stall", 32'(bus.stall), 32'd1);
            check("load_use_cnt", bus.stall_cnt, 32'(k));
            step();
        end
        idle();
        #1 check("load_use_cnt_end", bus.stall_cnt, 32'd3);
        step();

        // long op: stall, completion forward, bypass, then RF value
        idle();
        do_reset();
        bus.lo_issue = 1'b1; bus.lo_rd = 5'd9;
        step();
        bus.lo_issue = 1'b0;
        bus.id_rs_addr[0] = 5'd9; bus.id_rs_val[0] = 32'h5555;
        for (int k = 0; k < 3; k++) begin
            #1 check("lo_pending_stall", 32'(bus.stall), 32'd1);
            step();
        end
        bus.lo_done = 1'b1; bus.lo_res = 32'hABCD;
        #1;
        check("lo_done_stall", 32'(bus.stall), 32'd0);
        check("lo_done_fwd", bus.rs_mod[0], 32'hABCD);
        step();
        bus.lo_done = 1'b0; bus.lo_res = 32'h0;
        #1 check("lo_bypass_fwd", bus.rs_mod[0], 32'hABCD);
        step();
        #1 check("lo_after_bypass", bus.rs_mod[0], 32'h5555);
        step();

        // fill, issue+done while full, then overflow
        idle();
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            bus.lo_issue = 1'b1; bus.lo_rd = 5'(k);
            step();
        end
        bus.lo_issue = 1'b0;
        #1 check("full_after_4", 32'(bus.lo_full), 32'd1);
        check("no_err_after_4", 32'(bus.lo_err), 32'd0);
        bus.lo_issue = 1'b1; bus.lo_rd = 5'd10; bus.lo_done = 1'b1;
        step();
        bus.lo_done = 1'b0;
        #1 check("full_after_swap", 32'(bus.lo_full), 32'd1);
        check("no_err_after_swap", 32'(bus.lo_err), 32'd0);
        step();
        bus.lo_issue = 1'b0;
        #1 check("full_after_ovf", 32'(bus.lo_full), 32'd1);
        check("err_after_ovf", 32'(bus.lo_err), 32'd1);
        step();

        // underflow, no bypass capture, then reset mid-queue
        idle();
        do_reset();
        bus.lo_done = 1'b1; bus.lo_res = 32'hDEAD;
        step();
        bus.lo_done = 1'b0;
        bus.id_rs_addr[0] = 5'd0;
        bus.id_rs_addr[1] = 5'd5; bus.id_rs_val[1] = 32'h1234;
        #1 check("underflow_err", 32'(bus.lo_err), 32'd1);
        check("underflow_no_byp", bus.rs_mod[1], 32'h1234);
        step();
        bus.lo_issue = 1'b1; bus.lo_rd = 5'd3; step();
        bus.lo_rd = 5'd4; step();
        bus.lo_issue = 1'b0;
        bus.id_rs_addr[0] = 5'd3;
        #1 check("mid_queue_stall", 32'(bus.stall), 32'd1);
        step();
        do_reset();
        #1 check("post_reset_no_stall", 32'(bus.stall), 32'd0);
        check("post_reset_rs", bus.rs_mod[0], bus.id_rs_val[0]);
        step();

        // register 0 never forwards or stalls
        idle();
        do_reset();
        bus.lo_issue = 1'b1; bus.lo_rd = 5'd0;
        step();
        bus.id_rs_val[0] = 32'hFFFF_0001; bus.id_rs_val[1] = 32'hFFFF_0002;
        bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd0; bus.ex_res = 32'h77;
        bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd0; bus.wb_res = 32'h88;
        bus.lo_issue = 1'b1; bus.lo_rd = 5'd0; bus.lo_done = 1'b1; bus.lo_res = 32'h99;
        #1;
        check("x0_rs0", bus.rs_mod[0], 32'd0);
        check("x0_rs1", bus.rs_mod[1], 32'd0);
        check("x0_stall", 32'(bus.stall), 32'd0);
        step();

        // randomized traffic
        idle();
        do_reset();
        repeat (3000) begin
            for (int unsigned p = 0; p < NPORT; p++) begin
                bus.id_rs_addr[p] = 5'($urandom_range(0, 7));
                bus.id_rs_val[p]  = $urandom;
            end
            bus.ex_regwrite = 1'($urandom_range(0, 1));
            bus.ex_memread  = ($urandom_range(0, 3) == 0);
            bus.ex_rd       = 5'($urandom_range(0, 7));
            bus.ex_res      = $urandom;
            bus.wb_regwrite = 1'($urandom_range(0, 1));
            bus.wb_rd       = 5'($urandom_range(0, 7));
            bus.wb_res      = $urandom;
            bus.lo_issue    = ($urandom_range(0, 2) == 0);
            bus.lo_rd       = 5'($urandom_range(0, 7));
            bus.lo_done     = ($urandom_range(0, 2) == 0);
            bus.lo_res      = $urandom;
            if ($urandom_range(0, 199) == 0) do_reset();
            else step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
